// File: rtl/rename_pkg.sv
// Shared types and sizing for the rename free-list controller slice.
package rename_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } rfc_state_e;

  localparam int PHY_REG_NUM_DEF = 64;
  localparam int PREG_W          = $clog2(PHY_REG_NUM_DEF);
  localparam int CNT_W           = $clog2(PHY_REG_NUM_DEF + 1);

  function automatic int popcnt(input logic [31:0] v);
    int n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/arch_fl_tracker.sv
// Architectural free-list head/tail/count tracking driven by commit, with a
// sticky error flag for count underflow/overflow.
module arch_fl_tracker
  import rename_pkg::*;
#(
  parameter int PHY_REG_NUM  = PHY_REG_NUM_DEF,
  parameter int COMMIT_WIDTH = 4,
  parameter int PTR_BITS     = rename_pkg::PREG_W,
  parameter int CNT_BITS     = rename_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COMMIT_WIDTH-1:0] commit_alloc,
  input  logic [COMMIT_WIDTH-1:0] commit_free,
  output logic [PTR_BITS-1:0]     head,
  output logic [PTR_BITS-1:0]     tail,
  output logic [CNT_BITS-1:0]     cnt,
  output logic                    err
);

  logic [PTR_BITS-1:0] head_q, tail_q, head_nxt, tail_nxt;
  logic [CNT_BITS-1:0] cnt_q, cnt_nxt;
  logic                err_q, bound_hit;
  int                  n_a, n_f, raw;

  always_comb begin
    n_a       = popcnt(32'(commit_alloc));
    n_f       = popcnt(32'(commit_free));
    // Pointers wrap naturally because PHY_REG_NUM is a power of two.
    head_nxt  = PTR_BITS'(int'(head_q) + n_a);
    tail_nxt  = PTR_BITS'(int'(tail_q) + n_f);
    raw       = int'(cnt_q) + n_f - n_a;
    bound_hit = 1'b0;
    cnt_nxt   = CNT_BITS'(raw);
    if (raw < 0) begin
      cnt_nxt   = '0;
      bound_hit = 1'b1;
    end else if (raw > PHY_REG_NUM) begin
      cnt_nxt   = CNT_BITS'(PHY_REG_NUM);
      bound_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= CNT_BITS'(PHY_REG_NUM);
      err_q  <= 1'b0;
    end else begin
      head_q <= head_nxt;
      tail_q <= tail_nxt;
      cnt_q  <= cnt_nxt;
      err_q  <= err_q | bound_hit;
    end
  end

  assign head = head_nxt;
  assign tail = tail_nxt;
  assign cnt  = cnt_nxt;
  assign err  = err_q;

endmodule

// File: rtl/rename_freelist_ctrl.sv
// Gates decode allocation into the free list and sequences redirect recovery
// (one flush cycle followed by a fixed rename stall window).
module rename_freelist_ctrl
  import rename_pkg::*;
#(
  parameter int PHY_REG_NUM    = PHY_REG_NUM_DEF,
  parameter int DECODE_WIDTH   = 4,
  parameter int COMMIT_WIDTH   = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DECODE_WIDTH-1:0]          dec_valid_i,
  output logic                             dec_ready_o,
  output logic [DECODE_WIDTH-1:0]          fl_alloc_valid_o,
  input  logic                             fl_alloc_ready_i,
  input  logic [COMMIT_WIDTH-1:0]          commit_alloc_i,
  input  logic [COMMIT_WIDTH-1:0]          commit_free_i,
  output logic [COMMIT_WIDTH-1:0]          fl_free_valid_o,
  input  logic                             redirect_i,
  output logic                             fl_flush_o,
  output logic [$clog2(PHY_REG_NUM)-1:0]   arch_head_o,
  output logic [$clog2(PHY_REG_NUM)-1:0]   arch_tail_o,
  output logic [$clog2(PHY_REG_NUM+1)-1:0] arch_cnt_o,
  output logic                             busy_o,
  output logic                             err_o
);

  localparam int RC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  rfc_state_e      state, state_nxt;
  logic [RC_W-1:0] rcnt, rcnt_nxt;

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    case (state)
      RUN: begin
        if (redirect_i) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (redirect_i) begin
          state_nxt = FLUSH;
        end else begin
          state_nxt = RECOVER;
          rcnt_nxt  = RC_W'(RECOVER_CYCLES - 1);
        end
      end
      RECOVER: begin
        // A redirect here restarts the whole flush/recover sequence.
        if (redirect_i)        state_nxt = FLUSH;
        else if (rcnt == '0)   state_nxt = RUN;
        else                   rcnt_nxt  = rcnt - RC_W'(1);
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  assign dec_ready_o      = (state == RUN) & fl_alloc_ready_i & ~redirect_i;
  assign fl_alloc_valid_o = dec_ready_o ? dec_valid_i : '0;
  assign fl_free_valid_o  = commit_free_i;
  assign fl_flush_o       = (state == FLUSH);
  assign busy_o           = (state != RUN);

  arch_fl_tracker #(
    .PHY_REG_NUM  (PHY_REG_NUM),
    .COMMIT_WIDTH (COMMIT_WIDTH),
    .PTR_BITS     ($clog2(PHY_REG_NUM)),
    .CNT_BITS     ($clog2(PHY_REG_NUM+1))
  ) u_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .commit_alloc (commit_alloc_i),
    .commit_free  (commit_free_i),
    .head         (arch_head_o),
    .tail         (arch_tail_o),
    .cnt          (arch_cnt_o),
    .err          (err_o)
  );

endmodule

// File: tb/tb_rename_freelist_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a cycle-indexed behavioural model.
module tb_rename_freelist_ctrl;

  localparam int PRN = 64;
  localparam int DW  = 4;
  localparam int CW  = 4;
  localparam int RC  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] dv;
  logic          dec_ready_o;
  logic [DW-1:0] fl_alloc_valid_o;
  logic          far;
  logic [CW-1:0] ca, cf;
  logic [CW-1:0] fl_free_valid_o;
  logic          rd;
  logic          fl_flush_o;
  logic [5:0]    arch_head_o, arch_tail_o;
  logic [6:0]    arch_cnt_o;
  logic          busy_o, err_o;

  always #5 clk = ~clk;

  rename_freelist_ctrl #(
    .PHY_REG_NUM    (PRN),
    .DECODE_WIDTH   (DW),
    .COMMIT_WIDTH   (CW),
    .RECOVER_CYCLES (RC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dec_valid_i      (dv),
    .dec_ready_o      (dec_ready_o),
    .fl_alloc_valid_o (fl_alloc_valid_o),
    .fl_alloc_ready_i (far),
    .commit_alloc_i   (ca),
    .commit_free_i    (cf),
    .fl_free_valid_o  (fl_free_valid_o),
    .redirect_i       (rd),
    .fl_flush_o       (fl_flush_o),
    .arch_head_o      (arch_head_o),
    .arch_tail_o      (arch_tail_o),
    .arch_cnt_o       (arch_cnt_o),
    .busy_o           (busy_o),
    .err_o            (err_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_redir = -1000;
  int m_head = 0, m_tail = 0, m_cnt = PRN;
  bit m_err = 1'b0;

  function automatic logic [3:0] mask(input int k);
    return 4'((1 << k) - 1);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Mid-cycle: compare every output against the model.
  task automatic sample();
    int na, nf, raw, e_cnt, age;
    bit e_rdy;
    #4;
    na    = $countones(ca);
    nf    = $countones(cf);
    raw   = m_cnt + nf - na;
    e_cnt = (raw < 0) ? 0 : ((raw > PRN) ? PRN : raw);
    age   = cyc - last_redir;
    e_rdy = (age > 1 + RC) && far && !rd;
    chk("dec_ready", int'(dec_ready_o), int'(e_rdy));
    chk("fl_alloc_valid", int'(fl_alloc_valid_o), e_rdy ? int'(dv) : 0);
    chk("fl_free_valid", int'(fl_free_valid_o), int'(cf));
    chk("fl_flush", int'(fl_flush_o), int'(age == 1));
    chk("busy", int'(busy_o), int'(age >= 1 && age <= 1 + RC));
    chk("arch_head", int'(arch_head_o), (m_head + na) % PRN);
    chk("arch_tail", int'(arch_tail_o), (m_tail + nf) % PRN);
    chk("arch_cnt", int'(arch_cnt_o), e_cnt);
    chk("err", int'(err_o), int'(m_err));
  endtask

  // Clock edge: update the model with the inputs applied this cycle.
  task automatic advance();
    int na, nf, raw;
    @(posedge clk);
    na = $countones(ca);
    nf = $countones(cf);
    if (!rst_n) begin
      m_head = 0; m_tail = 0; m_cnt = PRN; m_err = 1'b0;
      last_redir = -1000;
    end else begin
      m_head = (m_head + na) % PRN;
      m_tail = (m_tail + nf) % PRN;
      raw = m_cnt + nf - na;
      if (raw < 0) begin m_cnt = 0; m_err = 1'b1; end
      else if (raw > PRN) begin m_cnt = PRN; m_err = 1'b1; end
      else m_cnt = raw;
      if (rd) last_redir = cyc;
    end
    cyc++;
    #1;
  endtask

  initial begin
    int s_na, s_nf;
    rst_n = 1'b0; dv = '0; far = 1'b0; ca = '0; cf = '0; rd = 1'b0;
    advance();
    advance();

    // Reset state and full-group acceptance.
    rst_n = 1'b1; dv = 4'b1111; far = 1'b1;
    sample();
    chk("lit_reset_head", int'(arch_head_o), 0);
    chk("lit_reset_tail", int'(arch_tail_o), 0);
    chk("lit_reset_cnt", int'(arch_cnt_o), 64);
    chk("lit_accept_ready", int'(dec_ready_o), 1);
    chk("lit_accept_valid", int'(fl_alloc_valid_o), 15);
    advance();

    // Free list not ready: nothing accepted.
    far = 1'b0; dv = 4'b0011;
    sample();
    chk("lit_noready_ready", int'(dec_ready_o), 0);
    chk("lit_noready_valid", int'(fl_alloc_valid_o), 0);
    advance();

    // Walk head/tail to 62, then wrap.
    far = 1'b1; dv = 4'b1111;
    repeat (15) begin ca = 4'b1111; cf = 4'b1111; sample(); advance(); end
    ca = 4'b0011; cf = 4'b0011; sample(); advance();
    ca = 4'b0111; cf = 4'b0001;
    sample();
    chk("lit_wrap_head", int'(arch_head_o), 1);
    chk("lit_wrap_cnt", int'(arch_cnt_o), 62);
    chk("lit_wrap_tail63", int'(arch_tail_o), 63);
    advance();
    ca = 4'b1111; cf = 4'b1111;
    sample();
    chk("lit_wrap_tail", int'(arch_tail_o), 3);
    chk("lit_wrap_head5", int'(arch_head_o), 5);
    advance();
    ca = '0; cf = '0;

    // Single redirect with a concurrent commit free.
    rd = 1'b1; cf = 4'b0011;
    sample();
    chk("lit_redir_tail", int'(arch_tail_o), 5);
    chk("lit_redir_ready", int'(dec_ready_o), 0);
    chk("lit_redir_flush", int'(fl_flush_o), 0);
    advance();
    rd = 1'b0; cf = '0;
    for (int k = 1; k <= 4; k++) begin
      sample();
      chk("lit_redir_flush_k", int'(fl_flush_o), int'(k == 1));
      chk("lit_redir_ready_k", int'(dec_ready_o), int'(k == 4));
      advance();
    end

    // Second redirect during RECOVER extends the stall.
    rd = 1'b1; sample(); advance();
    rd = 1'b0; sample();
    chk("lit_b2b_flush1", int'(fl_flush_o), 1);
    advance();
    rd = 1'b1; sample();
    chk("lit_b2b_ready2", int'(dec_ready_o), 0);
    advance();
    rd = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      sample();
      chk("lit_b2b_flush_k", int'(fl_flush_o), int'(k == 3));
      chk("lit_b2b_ready_k", int'(dec_ready_o), int'(k == 6));
      advance();
    end

    // Reset during recovery returns straight to RUN.
    rd = 1'b1; sample(); advance();
    rd = 1'b0; rst_n = 1'b0; sample(); advance();
    rst_n = 1'b1;
    sample();
    chk("lit_rstrec_busy", int'(busy_o), 0);
    chk("lit_rstrec_flush", int'(fl_flush_o), 0);
    chk("lit_rstrec_ready", int'(dec_ready_o), 1);
    advance();

    // Overflow: free at full count saturates and sets sticky error.
    cf = 4'b0001;
    sample();
    chk("lit_ovf_cnt", int'(arch_cnt_o), 64);
    advance();
    cf = '0;
    repeat (3) begin
      sample();
      chk("lit_ovf_err", int'(err_o), 1);
      chk("lit_ovf_cnt_hold", int'(arch_cnt_o), 64);
      advance();
    end
    rst_n = 1'b0; sample(); advance();
    rst_n = 1'b1;
    sample();
    chk("lit_err_cleared", int'(err_o), 0);
    advance();

    // Underflow: drain to zero, then allocate one more.
    ca = 4'b1111;
    repeat (16) begin sample(); advance(); end
    ca = 4'b0001;
    sample();
    chk("lit_udf_cnt", int'(arch_cnt_o), 0);
    advance();
    ca = '0;
    sample();
    chk("lit_udf_err", int'(err_o), 1);
    advance();
    rst_n = 1'b0; sample(); advance();
    rst_n = 1'b1;

    // Randomized traffic that keeps the count legal.
    repeat (3000) begin
      rd    = ($urandom_range(0, 11) == 0);
      far   = ($urandom_range(0, 3) != 0);
      dv    = mask(int'($urandom_range(0, 4)));
      s_na  = int'($urandom_range(0, imin(4, m_cnt)));
      s_nf  = int'($urandom_range(0, imin(4, PRN - m_cnt + s_na)));
      ca    = mask(s_na);
      cf    = mask(s_nf);
      rst_n = ($urandom_range(0, 299) != 0);
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rename_freelist_ctrl.md
# rename_freelist_ctrl

Controller sitting between decode/rename and the physical-register free list. It gates decode allocation groups into the free list, tracks the architectural free-list state (head, tail, count) from commit, and sequences redirect recovery. Recovery issues a one-cycle flush that restores the free list to architectural state, then holds rename for a fixed drain window.

## Interface
- PHY_REG_NUM, 64, physical register count; power of two
- DECODE_WIDTH, `DECODE_WIDTH, allocation slots per cycle
- COMMIT_WIDTH, `COMMIT_WIDTH, commit slots per cycle
- RECOVER_CYCLES, 2, rename stall cycles after flush; ≥1
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset; synchronous, active-low
- dec_valid_i  in  DECODE_WIDTH  per-slot allocation request; contiguous from bit 0
- dec_ready_o  out  1  decode group accepted this cycle
- fl_alloc_valid_o  out  DECODE_WIDTH  allocation request to free list
- fl_alloc_ready_i  in  1  free list has ≥DECODE_WIDTH entries
- commit_alloc_i  in  COMMIT_WIDTH  committing instr owns a new preg; contiguous
- commit_free_i  in  COMMIT_WIDTH  committing instr releases an old preg; contiguous
- fl_free_valid_o  out  COMMIT_WIDTH  free request to free list
- redirect_i  in  1  backend redirect pulse
- fl_flush_o  out  1  free-list flush
- arch_head_o  out  $clog2(PHY_REG_NUM)  architectural head
- arch_tail_o  out  $clog2(PHY_REG_NUM)  architectural tail
- arch_cnt_o  out  $clog2(PHY_REG_NUM+1)  architectural free count
- busy_o  out  1  recovery in progress (state ≠ RUN)
- err_o  out  1  sticky accounting error

## Operation
- States:
  - RUN: normal operation.
  - FLUSH: lasts exactly one cycle.
  - RECOVER: lasts RECOVER_CYCLES cycles, counted by a down-counter.
- Transitions:
  - RUN→FLUSH when redirect_i=1.
  - FLUSH→RECOVER, loading the counter with RECOVER_CYCLES−1.
  - RECOVER→RUN when the counter is 0 and redirect_i=0; otherwise the counter decrements.
  - redirect_i=1 in FLUSH or RECOVER forces the next state to FLUSH.
- Decode gating:
  - dec_ready_o = (state==RUN) & fl_alloc_ready_i & ~redirect_i.
  - fl_alloc_valid_o = dec_valid_i when dec_ready_o=1, else 0.
  - A group is never partially accepted.
- Frees:
  - fl_free_valid_o = commit_free_i in every state; commit is never blocked.
- Architectural tracking:
  - Let n_a = popcount(commit_alloc_i) and n_f = popcount(commit_free_i).
  - Next values: head+n_a and tail+n_f, both modulo PHY_REG_NUM (natural wrap), and cnt+n_f−n_a.
  - These are registered every cycle in all states.
- arch_*_o present the next values combinationally (registered value plus this cycle's commit). The flush therefore includes frees committed in the flush cycle itself.
- fl_flush_o = (state==FLUSH).
- err_o sets permanently (until reset) if a cnt update would go below 0 or above PHY_REG_NUM. When that happens the cnt register saturates at the bound.

## Timing
- Reset values:
  - state RUN, counter 0, err_o 0.
  - arch head/tail 0, cnt PHY_REG_NUM; arch_*_o therefore show 0/0/PHY_REG_NUM with no commit.
  - fl_flush_o 0, busy_o 0.
- Redirect in cycle t:
  - dec_ready_o=0 at t.
  - fl_flush_o=1 at t+1.
  - dec_ready_o=0 through t+1+RECOVER_CYCLES.
  - First acceptance possible at t+2+RECOVER_CYCLES.
- Decode-path latency is zero (combinational); the control path has one register stage.
- Simultaneous commit and redirect: the commit is counted normally.
- Back-to-back redirects extend recovery; fl_flush_o pulses once per redirect, one cycle later.
- Reset asserted mid-recovery returns to RUN on the next edge; no flush is issued.

## Structure
- Shared package rename_pkg:
  - enum rfc_state_e {RUN, FLUSH, RECOVER}.
  - localparams PREG_W = $clog2(PHY_REG_NUM) and CNT_W = $clog2(PHY_REG_NUM+1).
- One sub-module, arch_fl_tracker:
  - Holds the head/tail/cnt registers, popcounts, next-value outputs and the error flag.
  - Top level holds the FSM, recover counter and gating.

## Test plan
All scenarios use DECODE_WIDTH=4, COMMIT_WIDTH=4, PHY_REG_NUM=64, RECOVER_CYCLES=2.
- Reset, then idle: arch_* = 0/0/64; dec_valid_i=4'b1111 with fl_alloc_ready_i=1 → dec_ready_o=1 and fl_alloc_valid_o=4'b1111 in the same cycle.
- fl_alloc_ready_i=0 with dec_valid_i=4'b0011 → dec_ready_o=0 and fl_alloc_valid_o=0.
- Commit wrap: head=62, commit_alloc_i=4'b0111 → next head=1, arch_cnt_o = cnt−3; commit_free_i=4'b1111 at tail=63 → tail=3.
- Redirect at t=10 with commit_free_i=4'b0011 → fl_flush_o=1 only at t=11, arch_tail_o includes +2, dec_ready_o=0 for t=10..13, dec_ready_o=1 at t=14.
- Second redirect at t=12 (RECOVER) → fl_flush_o=1 at t=13, dec_ready_o=1 again first at t=16.
- cnt=64 with commit_free_i=4'b0001 and no alloc → err_o=1 and stays 1, cnt remains 64; rst_n=0 for one edge clears err_o.
